// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store access controller.
//   - Funct3 encodings for the supported loads and stores
//   - lsu_state_t: controller sequencing states
//   - size_of():  access size in bytes for a Funct3 code
//   - f3_legal(): whether a Funct3 code is legal for a load or for a store
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    ISSUE1 = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  // Access size in bytes; illegal codes never reach the datapath,
  // so their size is irrelevant and reported as a full word.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    logic [2:0] sz;
    case (funct3)
      F3_B, F3_BU: sz = 3'd1;
      F3_H, F3_HU: sz = 3'd2;
      default:     sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Stores only exist in signed flavours; loads also have BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the access controller.
//   funct3_i  access type          off_i   byte offset within the word
//   wdata_i   right-aligned store data
//   lo_i/hi_i first / second read word (hi_i is zero for non-split loads)
//   be8_o     byte enables over two consecutive words
//   wd64_o    lane-positioned store data over two consecutive words
//   rdata_o   extracted and extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  be8_o,
  output logic [63:0] wd64_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  mask_s;
  logic [63:0] word64_s;

  // Byte-enable / write-data positioning and load extraction/extension.
  always_comb begin
    mask_s = 8'h00;
    case (size_of(funct3_i))
      3'd1:    mask_s = 8'h01;
      3'd2:    mask_s = 8'h03;
      default: mask_s = 8'h0F;
    endcase
    be8_o    = mask_s << off_i;
    wd64_o   = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
    word64_s = {hi_i, lo_i} >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{word64_s[7]}}, word64_s[7:0]};
      F3_BU:   rdata_o = {24'h00_0000, word64_s[7:0]};
      F3_H:    rdata_o = {{16{word64_s[15]}}, word64_s[15:0]};
      F3_HU:   rdata_o = {16'h0000, word64_s[15:0]};
      default: rdata_o = word64_s[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: load/store initiator between execute stage and a
// word-organised data memory. Splits word-crossing accesses in two.
//   clk/reset              clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only when idle)
//   req_we/addr/funct3/wdata  request fields
//   rsp_valid/rdata/err    one-cycle completion pulse and its data
//   mem_addr/wr/wdata      word address, byte enables, lane data
//   mem_rdata              word read at the previous cycle's mem_addr
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t              state_q, state_d;
  logic                    we_q, we_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d, lo_q, lo_d;
  logic                    req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
  logic [DM_ADDRESS-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]              mem_wr_q, mem_wr_d;

  logic                    cur_we_s, split_s, accept_s;
  logic [DM_ADDRESS-1:0]   cur_addr_s, w0_s, w1_s;
  logic [2:0]              cur_f3_s;
  logic [DATA_W-1:0]       cur_wdata_s, lo_s, hi_s, rdata_s;
  logic [7:0]              be8_s;
  logic [63:0]             wd64_s;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

  // Outputs are registered, so the first issue cycle must be computed
  // from the live request while idle, and from latched fields afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we_s    = req_we;
      cur_addr_s  = req_addr;
      cur_f3_s    = req_funct3;
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = we_q;
      cur_addr_s  = addr_q;
      cur_f3_s    = f3_q;
      cur_wdata_s = wdata_q;
    end
    accept_s = (state_q == IDLE) && req_valid;
    split_s  = ({2'b00, cur_addr_s[1:0]} + {1'b0, size_of(cur_f3_s)}) > 4'd4;
    w0_s     = {cur_addr_s[DM_ADDRESS-1:2], 2'b00};
    w1_s     = w0_s + DM_ADDRESS'(3'd4);
  end

  // Read-word selection: in WAIT after a split, mem_rdata is the upper word.
  always_comb begin
    if ((state_q == WAIT) && split_s) begin
      lo_s = lo_q;
      hi_s = mem_rdata;
    end else begin
      lo_s = mem_rdata;
      hi_s = {DATA_W{1'b0}};
    end
  end

  lsu_align u_align (
    .funct3_i (cur_f3_s),
    .off_i    (cur_addr_s[1:0]),
    .wdata_i  (cur_wdata_s),
    .lo_i     (lo_s),
    .hi_i     (hi_s),
    .be8_o    (be8_s),
    .wd64_o   (wd64_s),
    .rdata_o  (rdata_s)
  );

  // Sequencing and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 4'b0000;
    mem_wdata_d = {DATA_W{1'b0}};
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d    = req_we;
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          if (!f3_legal(req_we, req_funct3)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
          end else begin
            state_d    = ISSUE0;
            mem_addr_d = w0_s;
            if (req_we) begin
              mem_wr_d    = be8_s[3:0];
              mem_wdata_d = wd64_s[31:0];
            end else begin
              mem_wr_d = 4'b0000;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE0: begin
        if (split_s) begin
          state_d    = ISSUE1;
          mem_addr_d = w1_s;
          if (we_q) begin
            mem_wr_d    = be8_s[7:4];
            mem_wdata_d = wd64_s[63:32];
          end else begin
            mem_wr_d = 4'b0000;
          end
        end else if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = WAIT;
        end
      end
      ISSUE1: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = WAIT;
          lo_d    = mem_rdata;
        end
      end
      WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rdata_s;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= {DM_ADDRESS{1'b0}};
      f3_q        <= 3'b000;
      wdata_q     <= {DATA_W{1'b0}};
      lo_q        <= {DATA_W{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= {DM_ADDRESS{1'b0}};
      mem_wr_q    <= 4'b0000;
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Load/store initiator that sits between the core's execute stage and the word-organised data memory.
- Accepts one request per handshake: address, Funct3 and write data.
- Drives word-aligned memory accesses with byte enables, and splits accesses that cross a word boundary into two word transactions.
- Returns aligned, sign- or zero-extended load data with a valid pulse.

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle; request is accepted when req_valid and req_ready are both high.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  DM_ADDRESS  byte address.
- req_funct3  input  3  instruction bits 14:12.
- req_wdata  input  DATA_W  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  output  1  illegal Funct3; qualified by rsp_valid.
- mem_addr  output  DM_ADDRESS  word address; bits [1:0] always 0.
- mem_wr  output  4  byte write enables; bit i enables byte lane i.
- mem_wdata  output  DATA_W  lane-positioned write data.
- mem_rdata  input  DATA_W  word read at the mem_addr driven in the previous cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: any state returns to IDLE at the next edge. No further mem_wr and no rsp_valid for the aborted request. A half-completed split store is not rolled back.
- Legal Funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is illegal.
- Size and split: size = 1, 2 or 4 bytes; off = addr[1:0]; split when off+size > 4.
- Word addresses: w0 = {addr[DM_ADDRESS-1:2], 2'b00}; w1 = w0+4, wrapping modulo 2^DM_ADDRESS (e.g. 0x1FC wraps to 0x000).
- Byte enables: be8 = (size mask) << off; mem_wr = be8[3:0] for w0 and be8[7:4] for w1.
- Write data: wd64 = {32'b0, wdata} << 8*off; lo half goes with w0, hi half with w1.
- Load data: word64 = {hi, lo} >> 8*off, keep size bytes. LB and LH sign-extend; LBU, LHU and LW zero-extend. For non-split loads, hi = 0.
- States:
  - IDLE: req_ready=1; mem_wr=0.
    - Accept with illegal Funct3 → RESP with err=1; no memory access.
    - Accept otherwise → ISSUE0; request fields latched.
  - ISSUE0: mem_addr=w0; mem_wr=be0 for stores, 0 for loads.
    - Store → ISSUE1 if split, else RESP.
    - Load → ISSUE1 if split, else WAIT.
  - ISSUE1: mem_addr=w1.
    - Store: mem_wr=be1, then → RESP.
    - Load: capture mem_rdata as lo, then → WAIT.
  - WAIT (loads only): capture mem_rdata (hi if split, else lo) → RESP.
  - RESP: rsp_valid=1 for exactly one cycle with registered rsp_rdata and rsp_err → IDLE.
- Latency, with the accept edge at T:
  - Illegal Funct3: rsp_valid at T+1.
  - Aligned store: T+2.
  - Split store: T+3.
  - Aligned load: T+3.
  - Split load: T+4.
- Handshake: req_ready is high only in IDLE; req_valid is ignored in all other states. No back-to-back acceptance during RESP.
- rsp_rdata and rsp_err hold their values outside RESP; consumers qualify them with rsp_valid.
- mem_wdata is 0 whenever mem_wr == 0.

Decomposition:
- Package lsu_pkg:
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, ISSUE0, ISSUE1, WAIT, RESP}.
  - Function size_of(funct3).
- Sub-module lsu_align: purely combinational, owning be8, wd64 and the extract/extend path. Keeps the FSM module focused on sequencing.

Test Plan:
- SW addr 0x010, wdata 0xDEADBEEF → at T+1 mem_addr=0x010, mem_wr=1111, mem_wdata=0xDEADBEEF; rsp_valid at T+2, rsp_err=0.
- Word 0x010 = 0x80112233; LB addr 0x013 → rsp_rdata 0xFFFFFF80 at T+3; LBU addr 0x013 → 0x00000080; LHU addr 0x012 → 0x00008011.
- SH addr 0x013, wdata 0x0000ABCD:
  - ISSUE0: mem_addr=0x010, mem_wr=1000, mem_wdata[31:24]=0xCD.
  - ISSUE1: mem_addr=0x014, mem_wr=0001, mem_wdata[7:0]=0xAB.
  - Then LH addr 0x013 → 0xFFFFABCD at T+4.
- Word 0x1FC = 0x44332211, word 0x000 = 0x88776655; LW addr 0x1FE → mem_addr 0x1FC then 0x000; rsp_rdata 0x66554433.
- Load funct3=011, and separately store funct3=100 → mem_wr stays 0000; rsp_valid with rsp_err=1 at T+1; rsp_rdata=0.
- Reset asserted during ISSUE1 of a split SW → next cycle mem_wr=0, req_ready=1, no rsp_valid; a new SB then completes normally at T+2.
